// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO plus holding register and 2-state sequencer feeding the UART transmitter.
// Latency: push into an empty idle block -> tx_en/tx_data valid 2 edges later; the next byte follows tx_res by 1 edge.
// Backpressure: wr_ready = !full from the registered count; writes while full are dropped.
// Option: define UART_TX_FIFO_STATS_EN to add the sent_count / drop_count outputs.
module uart_tx_fifo #(
  parameter int  DATA_BITS = 8,
  parameter int  DEPTH     = 16,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_en,
  input  logic                 tx_res,
  output logic [ADDR_W:0]      level,
  output logic                 empty,
  output logic                 full
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic [15:0]          sent_count,
  output logic [15:0]          drop_count
`endif
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    rd_ptr;
  logic [ADDR_W:0]      count;
  logic                 has_data;
  logic                 push;
  logic                 pop;

  // Status flags come straight off the registered count so they never lag the edge.
  assign has_data = (count != '0);
  assign level    = count;
  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign wr_ready = !full;

  // A write is taken only when not full at the start of the cycle, even if a pop frees a slot.
  assign push = wr_valid && !full;
  // Pop whenever idle with data, or when the current frame finishes and more data waits.
  assign pop  = has_data && ((state == IDLE) || tx_res);

  // Storage array: no reset needed, the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer: holds one byte on tx_data while a frame is owed, reloads on tx_res.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (has_data) begin
            tx_data <= mem[rd_ptr];
            tx_en   <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (tx_res) begin
            if (has_data) begin
              tx_data <= mem[rd_ptr];
            end else begin
              tx_en <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_STATS_EN
  // Statistics: completed frames wrap, refused writes saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      sent_count <= '0;
      drop_count <= '0;
    end else begin
      if ((state == SEND) && tx_res) begin
        sent_count <= sent_count + 16'd1;
      end
      if (wr_valid && full && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic against a queue-based reference model.
// The model tracks occupancy and frame ownership; accepted bytes go into a scoreboard queue.
// A negedge monitor checks status outputs every cycle and matches each new frame byte against the scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] tx_data;
  logic          tx_en;
  logic          tx_res;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0]   sent_count;
  logic [15:0]   drop_count;
`endif

  uart_tx_fifo #(.DATA_BITS(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .tx_res   (tx_res),
    .level    (level),
    .empty    (empty),
    .full     (full)
`ifdef UART_TX_FIFO_STATS_EN
    ,
    .sent_count (sent_count),
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int            m_cnt    = 0;   // bytes waiting in the FIFO
  bit            m_send   = 0;   // a frame is owed to the transmitter
  bit            m_popped = 0;   // a new byte entered the holding register at the last edge
  bit            m_acc;
  int            m_sent   = 0;
  int            m_drop   = 0;
  logic [DW-1:0] exp_q[$];       // scoreboard: accepted bytes in transmit order
  logic [DW-1:0] cur      = '0;  // byte of the frame in progress
  bit            armed    = 0;
  bit            auto_tx  = 0;
  int            tmr      = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: occupancy, frame ownership and scoreboard feed, applied at each edge.
  always @(posedge clk) begin
    if (reset) begin
      m_cnt    = 0;
      m_send   = 0;
      m_popped = 0;
      m_sent   = 0;
      m_drop   = 0;
      exp_q.delete();
    end else begin
      m_popped = 0;
      if (m_send && tx_res) m_sent = (m_sent + 1) % 65536;
      if (wr_valid && (m_cnt == DEPTH) && (m_drop < 65535)) m_drop++;
      m_acc = wr_valid && (m_cnt < DEPTH);
      if ((m_cnt > 0) && (!m_send || tx_res)) begin
        m_cnt--;
        m_send   = 1;
        m_popped = 1;
      end else if (m_send && tx_res) begin
        m_send = 0;
      end
      if (m_acc) begin
        m_cnt++;
        exp_q.push_back(wr_data);
      end
    end
  end

  // Monitor: status outputs against the model, frame bytes against the scoreboard.
  always @(negedge clk) begin
    if (armed) begin
      chk("level", level, m_cnt);
      chk("empty", empty, m_cnt == 0);
      chk("full", full, m_cnt == DEPTH);
      chk("wr_ready", wr_ready, m_cnt < DEPTH);
      chk("tx_en", tx_en, m_send);
`ifdef UART_TX_FIFO_STATS_EN
      chk("sent_count", sent_count, m_sent);
      chk("drop_count", drop_count, m_drop);
`endif
      if (m_popped) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frame_byte: got %0h want nothing queued", tx_data);
        end else begin
          cur = exp_q.pop_front();
          chk("frame_byte", tx_data, cur);
        end
      end else if (tx_en) begin
        chk("tx_data_hold", tx_data, cur);
      end
    end
  end

  // One clock edge; inputs change 1ns after it. The optional transmitter model pulses tx_res.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_tx) begin
      if (tx_res) begin
        tx_res = 1'b0;
        tmr    = -1;
      end else if (tx_en) begin
        if (tmr < 0) tmr = int'($urandom_range(0, 4));
        if (tmr == 0) tx_res = 1'b1;
        else tmr--;
      end
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    wr_valid = 1'b0;
    tx_res   = 1'b0;
    tick();
    reset = 1'b0;
    tmr   = -1;
  endtask

  task automatic pulse_res();
    tick();
    tx_res = 1'b1;
    tick();
    tx_res = 1'b0;
  endtask

  logic [DW-1:0] burst [3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    tx_res   = 1'b0;

    // Reset then idle; tx_res while idle is ignored.
    do_reset();
    armed = 1;
    @(negedge clk);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_wr_ready", wr_ready, 1);
    tx_res = 1'b1;
    tick();
    tx_res = 1'b0;
    @(negedge clk);
    chk("idle_res_tx_en", tx_en, 0);
    chk("idle_res_level", level, 0);

    // Single byte: 2-edge latency, tx_en drops one edge after tx_res.
    wr_data  = 8'hA5;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("single_tx_en", tx_en, 1);
    chk("single_tx_data", tx_data, 8'hA5);
    chk("single_level", level, 0);
    tick();
    pulse_res();
    @(negedge clk);
    chk("single_end_tx_en", tx_en, 0);

    // Burst of 3 back-to-back frames.
    for (int i = 0; i < 3; i++) begin
      wr_data  = burst[i];
      wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("burst_first", tx_data, 8'h11);
    for (int k = 0; k < 3; k++) begin
      tick();
      pulse_res();
      @(negedge clk);
      chk("burst_tx_en", tx_en, (k < 2) ? 1 : 0);
      if (k < 2) chk("burst_data", tx_data, burst[k+1]);
    end

    // Full / overflow: 18 pushes with the transmitter stalled.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      wr_data  = DW'(i);
      wr_valid = 1'b1;
      tick();
      if (i == 16) begin
        @(negedge clk);
        chk("full_flag", full, 1);
        chk("full_wr_ready", wr_ready, 0);
        chk("full_level", level, DEPTH);
      end
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("ovf_level", level, DEPTH);
    chk("ovf_hold", tx_data, 8'h00);
    for (int i = 0; i < 17; i++) pulse_res();
    tick();
    @(negedge clk);
    chk("drain_tx_en", tx_en, 0);
    chk("drain_left", exp_q.size(), 0);
`ifdef UART_TX_FIFO_STATS_EN
    chk("stats_drop", drop_count, 1);
    chk("stats_sent", sent_count, 17);
`endif

    // Simultaneous push and frame completion with level 4.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_data  = DW'(8'h31 + i);
      wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("sim_pre_level", level, 4);
    chk("sim_pre_data", tx_data, 8'h31);
    wr_data  = 8'h7E;
    wr_valid = 1'b1;
    tx_res   = 1'b1;
    tick();
    wr_valid = 1'b0;
    tx_res   = 1'b0;
    @(negedge clk);
    chk("sim_level", level, 4);
    chk("sim_data", tx_data, 8'h32);

    // Random traffic with a running transmitter; many pointer wraps.
    auto_tx = 1;
    tmr     = -1;
    for (int c = 0; c < 400; c++) begin
      wr_valid = ($urandom_range(0, 99) < 45);
      wr_data  = DW'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    begin
      int n;
      n = 0;
      while ((m_cnt != 0 || m_send) && n < 400) begin
        tick();
        n++;
      end
      if (n >= 400) begin
        total++;
        bad++;
        $display("FAIL random_drain: got level %0d still pending want 0 within 400 cycles", m_cnt);
      end
    end
    auto_tx = 0;
    tx_res  = 1'b0;
    tick();
    @(negedge clk);
    chk("random_idle", tx_en, 0);

    // Reset in the middle of a frame with level 5.
    for (int i = 0; i < 6; i++) begin
      wr_data  = DW'(8'h41 + i);
      wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("mid_level", level, 5);
    chk("mid_tx_en", tx_en, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_en", tx_en, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_data", tx_data, 0);
    wr_data  = 8'h5A;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_tx_en", tx_en, 1);
    chk("post_rst_data", tx_data, 8'h5A);
    pulse_res();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
